// File: rtl/mem_hs_pkg.sv
// Shared types and constants for the handshake RAM: FSM state, bus widths and
// the encodings of the READ_WRITE / WORD_BYTE request qualifiers.
package mem_hs_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    localparam logic RW_READ = 1'b1;
    localparam logic WB_WORD = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    // Word accesses always target the naturally aligned 4-byte group.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// 256 x 8 storage with four byte-lane write enables. Lane k addresses byte
// addr_i + k; the read port returns the four consecutive bytes little-endian.
// The array has no reset, so contents survive a module reset.
module mem_byte_array
    import mem_hs_pkg::*;
(
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [7:0]        mem_q [MEM_DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    // Per-lane byte address; wraps modulo the array size.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_i + ADDR_W'(k);
        end
    end

    // Combinational read of the four bytes starting at addr_i.
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < 4; k++) begin
            rdata_o[8*k +: 8] = mem_q[lane_addr[k]];
        end
    end

    // Byte-lane writes.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) begin
                mem_q[lane_addr[k]] <= wdata_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_handshake_ram.sv
// Four-phase MFA/MFC handshake RAM, 256 bytes, byte or word access.
// A request is captured in IDLE, waits WAIT_CYCLES extra cycles plus one
// address setup cycle, then completes with MFC held until MFA drops.
// Optional feature: define MEM_ALIGN_ERR_EN to add the ALIGN_ERR output and
// reject misaligned word accesses instead of silently aligning them.
module mem_handshake_ram
    import mem_hs_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              READ_WRITE,
    input  logic              WORD_BYTE,
    input  logic [ADDR_W-1:0] MEMADD,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              MFC
`ifdef MEM_ALIGN_ERR_EN
    ,
    output logic              ALIGN_ERR
`endif
);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              setup_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic              wb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dout_q;
    logic              mfc_q;
    logic              aerr_q;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_value;
    logic              access;
    logic              align_bad;

`ifdef MEM_ALIGN_ERR_EN
    assign align_bad = (wb_q == WB_WORD) && (addr_q[1:0] != 2'b00);
`else
    assign align_bad = 1'b0;
`endif

    // The access fires on the last WAIT edge, provided the CPU still holds MFA.
    assign access = (state_q == StWait) && MFA && !setup_q && (cnt_q == 4'd0);

    // Effective address, write strobes/data and zero-extended read value.
    always_comb begin
        mem_addr  = (wb_q == WB_WORD) ? word_addr(addr_q) : addr_q;
        mem_we    = 4'b0000;
        mem_wdata = (wb_q == WB_WORD) ? wdata_q : {24'h0, wdata_q[7:0]};
        rd_value  = (wb_q == WB_WORD) ? mem_rdata : {24'h0, mem_rdata[7:0]};
        if (Reset && access && (rw_q != RW_READ) && !align_bad) begin
            mem_we = (wb_q == WB_WORD) ? 4'b1111 : 4'b0001;
        end
    end

    mem_byte_array u_mem (
        .clk_i   (Clk),
        .addr_i  (mem_addr),
        .we_i    (mem_we),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Handshake FSM with registered MFC, DATA_OUT and alignment flag.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            setup_q <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wb_q    <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (MFA) begin
                        addr_q  <= MEMADD;
                        rw_q    <= READ_WRITE;
                        wb_q    <= WORD_BYTE;
                        wdata_q <= DATA_IN;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        setup_q <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!MFA) begin
                        // Abandoned request: nothing written, outputs untouched.
                        cnt_q   <= 4'd0;
                        setup_q <= 1'b0;
                        state_q <= StIdle;
                    end else if (setup_q) begin
                        // Address settle cycle for the captured request.
                        setup_q <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= StDone;
                        mfc_q   <= 1'b1;
                        aerr_q  <= align_bad;
                        if (align_bad) begin
                            dout_q <= '0;
                        end else if (rw_q == RW_READ) begin
                            dout_q <= rd_value;
                        end
                    end
                end
                StDone: begin
                    if (!MFA) begin
                        mfc_q   <= 1'b0;
                        aerr_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign DATA_OUT = dout_q;
    assign MFC      = mfc_q;

`ifdef MEM_ALIGN_ERR_EN
    assign ALIGN_ERR = aerr_q;
`else
    // Flag is only observable with the alignment-error feature enabled.
    logic unused_aerr;
    assign unused_aerr = aerr_q;
`endif

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Self-checking bench for mem_handshake_ram: directed vector table, abort and
// reset sequences, then random transactions against a byte-array model.
module tb_mem_handshake_ram;

    localparam int unsigned WAIT = 2;

    logic        Clk;
    logic        Reset;
    logic        MFA;
    logic        READ_WRITE;
    logic        WORD_BYTE;
    logic [7:0]  MEMADD;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        MFC;
`ifdef MEM_ALIGN_ERR_EN
    logic        ALIGN_ERR;
`endif

    mem_handshake_ram #(.WAIT_CYCLES(WAIT)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MFA        (MFA),
        .READ_WRITE (READ_WRITE),
        .WORD_BYTE  (WORD_BYTE),
        .MEMADD     (MEMADD),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .MFC        (MFC)
`ifdef MEM_ALIGN_ERR_EN
        ,
        .ALIGN_ERR  (ALIGN_ERR)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain byte array plus the last value DATA_OUT should show.
    logic [7:0]  m_mem [256];
    logic [31:0] m_dout;

    typedef struct {
        bit          rw;
        bit          wb;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {m_mem[b + 8'd3], m_mem[b + 8'd2], m_mem[b + 8'd1], m_mem[b]};
    endfunction

    function automatic logic [31:0] model_xact(input bit rw, input bit wb,
                                               input logic [7:0] a, input logic [31:0] d);
        logic [7:0] b;
`ifdef MEM_ALIGN_ERR_EN
        if (wb && a[1:0] != 2'b00) begin
            m_dout = 32'h0;
            return m_dout;
        end
`endif
        b = wb ? (a & 8'hFC) : a;
        if (rw) begin
            m_dout = wb ? model_word(b) : {24'h0, m_mem[b]};
        end else if (wb) begin
            for (int k = 0; k < 4; k++) m_mem[b + 8'(k)] = d[8*k +: 8];
        end else begin
            m_mem[b] = d[7:0];
        end
        return m_dout;
    endfunction

    // One full four-phase transaction, checked against the model.
    task automatic xact(input bit rw, input bit wb, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] dout);
        logic [31:0] exp;
        int          lat;
        bit          seen;
        exp = model_xact(rw, wb, a, d);
        READ_WRITE = rw; WORD_BYTE = wb; MEMADD = a; DATA_IN = d; MFA = 1'b1;
        @(posedge Clk); #1;
        // Other inputs must be ignored after the capture edge.
        READ_WRITE = 1'($urandom); WORD_BYTE = 1'($urandom);
        MEMADD = 8'($urandom); DATA_IN = $urandom;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
            seen = MFC;
        end
        chk("mfc_latency", 32'(lat), 32'(WAIT + 2));
        dout = DATA_OUT;
        chk("dout_model", DATA_OUT, exp);
`ifdef MEM_ALIGN_ERR_EN
        chk("align_err", {31'h0, ALIGN_ERR}, {31'h0, (wb && a[1:0] != 2'b00)});
`endif
        @(posedge Clk); #1;
        chk("mfc_hold", {31'h0, MFC}, 32'h1);
        chk("dout_hold", DATA_OUT, dout);
        MFA = 1'b0;
        @(posedge Clk); #1;
        chk("mfc_release", {31'h0, MFC}, 32'h0);
`ifdef MEM_ALIGN_ERR_EN
        chk("align_err_release", {31'h0, ALIGN_ERR}, 32'h0);
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] dout;
        logic [31:0] prior;
        bit          seen;

        Reset = 1'b0; MFA = 1'b0; READ_WRITE = 1'b0; WORD_BYTE = 1'b0;
        MEMADD = 8'h0; DATA_IN = 32'h0;
        m_dout = 32'h0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_mfc", {31'h0, MFC}, 32'h0);
        chk("reset_dout", DATA_OUT, 32'h0);
`ifdef MEM_ALIGN_ERR_EN
        chk("reset_align_err", {31'h0, ALIGN_ERR}, 32'h0);
`endif
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Give every byte a known value so later reads are fully predictable.
        for (int i = 0; i < 64; i++) xact(1'b0, 1'b1, 8'(4 * i), $urandom, dout);

        vecs[0] = '{rw: 1'b0, wb: 1'b1, addr: 8'h00, data: 32'h0000CAFE, exp: 32'h00000000};
        vecs[1] = '{rw: 1'b1, wb: 1'b1, addr: 8'h00, data: 32'h0,        exp: 32'h0000CAFE};
        vecs[2] = '{rw: 1'b0, wb: 1'b1, addr: 8'h04, data: 32'hCAFE0000, exp: 32'h0000CAFE};
        vecs[3] = '{rw: 1'b1, wb: 1'b0, addr: 8'h07, data: 32'h0,        exp: 32'h000000CA};
        vecs[4] = '{rw: 1'b1, wb: 1'b0, addr: 8'h04, data: 32'h0,        exp: 32'h00000000};
        vecs[5] = '{rw: 1'b0, wb: 1'b0, addr: 8'h05, data: 32'hFFFFFFAB, exp: 32'h00000000};
        vecs[6] = '{rw: 1'b1, wb: 1'b1, addr: 8'h04, data: 32'h0,        exp: 32'hCAFEAB00};
`ifdef MEM_ALIGN_ERR_EN
        vecs[7] = '{rw: 1'b1, wb: 1'b1, addr: 8'h01, data: 32'h0,        exp: 32'h00000000};
        vecs[8] = '{rw: 1'b0, wb: 1'b1, addr: 8'h02, data: 32'h11223344, exp: 32'h00000000};
        vecs[9] = '{rw: 1'b1, wb: 1'b1, addr: 8'h00, data: 32'h0,        exp: 32'h0000CAFE};
`else
        vecs[7] = '{rw: 1'b1, wb: 1'b1, addr: 8'h01, data: 32'h0,        exp: 32'h0000CAFE};
        vecs[8] = '{rw: 1'b0, wb: 1'b1, addr: 8'h02, data: 32'h11223344, exp: 32'h0000CAFE};
        vecs[9] = '{rw: 1'b1, wb: 1'b1, addr: 8'h00, data: 32'h0,        exp: 32'h11223344};
`endif
        for (int i = 0; i < 10; i++) begin
            xact(vecs[i].rw, vecs[i].wb, vecs[i].addr, vecs[i].data, dout);
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp);
        end

        // Abort: drop MFA while the write is still waiting.
        prior = model_word(8'h08);
        READ_WRITE = 1'b0; WORD_BYTE = 1'b1; MEMADD = 8'h08; DATA_IN = 32'h12345678;
        MFA = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        MFA = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge Clk); #1;
            if (MFC) seen = 1'b1;
        end
        chk("abort_mfc", {31'h0, seen}, 32'h0);
        chk("abort_dout", DATA_OUT, m_dout);
        xact(1'b1, 1'b1, 8'h08, 32'h0, dout);
        chk("abort_no_write", dout, prior);

        // Reset during WAIT: access abandoned, outputs cleared, storage kept.
        prior = model_word(8'h0C);
        READ_WRITE = 1'b0; WORD_BYTE = 1'b1; MEMADD = 8'h0C; DATA_IN = 32'hAA55AA55;
        MFA = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("midreset_mfc", {31'h0, MFC}, 32'h0);
        chk("midreset_dout", DATA_OUT, 32'h0);
        m_dout = 32'h0;
        Reset = 1'b1;
        MFA = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        chk("midreset_idle_mfc", {31'h0, MFC}, 32'h0);
        xact(1'b1, 1'b1, 8'h0C, 32'h0, dout);
        chk("midreset_no_write", dout, prior);
        xact(1'b1, 1'b1, 8'h04, 32'h0, dout);
        chk("midreset_retained", dout, 32'hCAFEAB00);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            xact(1'($urandom), 1'($urandom), 8'($urandom), $urandom, dout);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
